// File: rtl/ram_readback_if.sv
// Signal bundle between ram_readback, its RAM read port and the word consumer.
// Handshake: a word on dout/dout_idx transfers on a rising edge where dout_valid and dout_ready are both 1;
// once raised, dout_valid and its payload hold until that edge, and dout_ready has no effect while dout_valid is 0.
interface ram_readback_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
    logic              chk_err;
    logic [ADDR_W-1:0] err_idx;
    logic [2:0]        fsm_state;

    modport master (
        input  start, doutb, dout_ready,
        output addrb, dout, dout_idx, dout_valid, busy, done, chk_err, err_idx, fsm_state
    );

    modport slave (
        output start, doutb, dout_ready,
        input  addrb, dout, dout_idx, dout_valid, busy, done, chk_err, err_idx, fsm_state
    );
endinterface

// File: rtl/ram_readback.sv
// Reads words 0..DEPTH-1 from a one-cycle-latency RAM, streams them out over a valid/ready port
// and flags the first word that breaks the Fibonacci rule word[i] = word[i-1] + word[i-2].
module ram_readback #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    ram_readback_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_CHK = ADDR_W'(2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] p1, p2;
    logic [DATA_W-1:0] fib_sum;
    logic              accept, hs, last, fib_bad;

    assign accept  = (state == S_IDLE) && bus.start;
    assign hs      = (state == S_OUT) && bus.dout_valid && bus.dout_ready;
    assign last    = (idx == LAST_IDX);
    // Sum is truncated to DATA_W so the check is modulo 2^DATA_W.
    assign fib_sum = p1 + p2;
    assign fib_bad = (idx >= FIRST_CHK) && (bus.dout != fib_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RD;
            S_RD:    state_nxt = S_CAP;
            S_CAP:   state_nxt = S_OUT;
            S_OUT:   if (hs) state_nxt = last ? S_DONE : S_RD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_DONE);
        bus.fsm_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            bus.addrb      <= '0;
            bus.dout       <= '0;
            bus.dout_idx   <= '0;
            bus.dout_valid <= 1'b0;
            bus.chk_err    <= 1'b0;
            bus.err_idx    <= '0;
            p1             <= '0;
            p2             <= '0;
        end else begin
            if (accept) begin
                idx         <= '0;
                bus.addrb   <= '0;
                bus.chk_err <= 1'b0;
                bus.err_idx <= '0;
            end
            if (state == S_CAP) begin
                bus.dout       <= bus.doutb;
                bus.dout_idx   <= idx;
                bus.dout_valid <= 1'b1;
            end
            if (hs) begin
                bus.dout_valid <= 1'b0;
                p2             <= p1;
                p1             <= bus.dout;
                // The last word leaves idx/addrb parked at DEPTH-1.
                if (!last) begin
                    idx       <= idx + 1'b1;
                    bus.addrb <= idx + 1'b1;
                end
                if (fib_bad && !bus.chk_err) begin
                    bus.chk_err <= 1'b1;
                    bus.err_idx <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_readback.sv
// Directed and randomized readback passes against a word-list model of the RAM contents,
// with the expected Fibonacci-failure index derived directly from the stored words.
module tb_ram_readback;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    ram_readback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_readback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset / RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.doutb <= mem[bus.addrb];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        mem[0] = a;
        mem[1] = b;
        for (int i = 2; i < (1 << ADDR_W); i++) mem[i] = mem[i-1] + mem[i-2];
    endtask

    function automatic int first_err();
        logic [DATA_W-1:0] s;
        for (int i = 2; i < DEPTH; i++) begin
            s = mem[i-1] + mem[i-2];
            if (mem[i] != s) return i;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.dout_valid, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_err"},   bus.chk_err, 0);
        check({tag, "_eidx"},  bus.err_idx, 0);
        check({tag, "_addrb"}, bus.addrb, 0);
        check({tag, "_dout"},  bus.dout, 0);
        check({tag, "_didx"},  bus.dout_idx, 0);
    endtask

    // One readback pass; stall_idx holds ready low 10 cycles on that word, repulse_idx pulses start
    // while that word is first valid, abort_idx pulses rst while that word is in its capture cycle.
    task automatic do_pass(input int ready_pct, input int stall_idx, input int repulse_idx, input int abort_idx);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp_word, h_dout;
        logic [ADDR_W-1:0] h_idx;
        int ref_cyc, hs_cyc, widx, stall_left, budget, exp_err, done_cnt;
        logic held, finished, aborted, rdy;

        exp_q = {};
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        exp_err    = first_err();
        widx       = 0;
        stall_left = 10;
        budget     = 3000;
        done_cnt   = 0;
        hs_cyc     = -1;
        held       = 1'b0;
        finished   = 1'b0;
        aborted    = 1'b0;
        h_dout     = '0;
        h_idx      = '0;

        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ref_cyc = cyc;
        check("acc_busy",  bus.busy, 1);
        check("acc_err",   bus.chk_err, 0);
        check("acc_eidx",  bus.err_idx, 0);
        check("acc_addrb", bus.addrb, 0);
        check("acc_valid", bus.dout_valid, 0);

        while (!finished && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (abort_idx >= 0 && widx == abort_idx && cyc == ref_cyc + 1) begin
                check("abort_in_cap", bus.fsm_state, 3'd2);
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                repeat (2) begin
                    @(posedge clk); #1;
                    check("abort_no_done", bus.done, 0);
                end
                @(negedge clk);
                rst = 1'b0;
                aborted  = 1'b1;
                finished = 1'b1;
            end else if (bus.done) begin
                done_cnt++;
                check("done_cyc", cyc, hs_cyc);
                check("done_busy", bus.busy, 1);
                check("done_words", widx, DEPTH);
                finished = 1'b1;
            end else if (bus.dout_valid) begin
                if (!held) begin
                    check("latency", cyc - ref_cyc, 2);
                    exp_word = exp_q.pop_front();
                    check("dout", bus.dout, exp_word);
                    check("dout_idx", bus.dout_idx, widx);
                    h_dout = bus.dout;
                    h_idx  = bus.dout_idx;
                end else begin
                    check("hold_dout", bus.dout, h_dout);
                    check("hold_idx", bus.dout_idx, h_idx);
                    check("hold_addrb", bus.addrb, widx);
                end
                bus.start = (widx == repulse_idx) && !held;
                if (widx == stall_idx && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = ($urandom_range(99) < ready_pct);
                end
                bus.dout_ready = rdy;
                if (rdy) begin
                    hs_cyc  = cyc + 1;
                    ref_cyc = cyc + 1;
                    widx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                end
            end else begin
                bus.start      = 1'b0;
                bus.dout_ready = 1'($urandom_range(1));
            end
        end
        bus.start      = 1'b0;
        bus.dout_ready = 1'b0;

        if (budget == 0) begin
            tests++;
            fails++;
            $error("FAIL timeout: observed %0d words expected %0d", widx, DEPTH);
        end else if (!aborted) begin
            check("queue_empty", exp_q.size(), 0);
            repeat (4) begin
                @(posedge clk); #1;
                check("post_done", bus.done, 0);
                check("post_busy", bus.busy, 0);
                check("post_err", bus.chk_err, (exp_err >= 0) ? 1 : 0);
                check("post_eidx", bus.err_idx, (exp_err >= 0) ? exp_err : 0);
            end
            check("done_count", done_cnt, 1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dout_ready = 1'b0;
        fill(32'd0, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean Fibonacci table, consumer always ready.
        do_pass(100, -1, -1, -1);

        // Word 7 corrupted: 7, 8 and 9 all mismatch, only 7 is reported.
        mem[7] = 32'hDEADBEEF;
        do_pass(100, -1, -1, -1);

        // Stall on word 4 for 10 cycles.
        fill(32'd0, 32'd1);
        do_pass(100, 4, -1, -1);

        // start re-pulsed during word 10, with an error so the next accept must clear it.
        mem[20] = 32'h1234_5678;
        do_pass(100, -1, 10, -1);
        fill(32'd0, 32'd1);
        do_pass(100, -1, -1, -1);

        // Reset during capture of word 15, then a fresh pass from address 0.
        do_pass(100, -1, -1, 15);
        do_pass(100, -1, -1, -1);

        // Word 3 is 0xFFFFFFFF + 2 wrapped to 1.
        fill(32'hFFFF_FFFD, 32'd2);
        do_pass(70, -1, -1, -1);

        // Random seeds, random corruption, random consumer back-pressure.
        for (int r = 0; r < 4; r++) begin
            fill($urandom, $urandom);
            if ($urandom_range(1) == 1) mem[$urandom_range(DEPTH-1, 2)] = $urandom;
            do_pass($urandom_range(100, 30), -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
